action_scheduler: RTL

ACTION_SCHEDULER -- requirements
Module: action_scheduler

---
 rtl/action_scheduler_if.sv | 20 ++
 rtl/action_scheduler.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/action_scheduler_if.sv
// Key-input strobe and action request/acknowledge bundle between keyboard decoder,
// scheduler and game logic.
interface action_scheduler_if;
  logic [7:0] key_code;
  logic       key_valid;
  logic       act_req;
  logic [1:0] act_code;
  logic       act_ack;

  // key_valid is a one-cycle strobe qualifying key_code. act_req/act_code rise together
  // and stay stable until act_ack is sampled high; act_req drops on the following cycle.
  modport master (
    input  key_code, key_valid, act_ack,
    output act_req, act_code
  );
  modport slave (
    output key_code, key_valid, act_ack,
    input  act_req, act_code
  );
endinterface

// File: rtl/action_scheduler.sv
// Merges gravity ticks and decoded keyboard actions into one request/acknowledge
// stream; gravity wins over queued keys, keys wait in a 4-deep FIFO.
module action_scheduler #(
  parameter int TICK_BASE = 50000000,
  parameter int TICK_STEP = 4000000,
  parameter int MAX_LEVEL = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_sig,
  input  logic [3:0]                level,
  action_scheduler_if.master        bus,
  output logic [2:0]                fifo_count,
  output logic                      overflow,
  output logic                      fsm_state
);

  localparam int CW = $clog2(TICK_BASE + 1);
  localparam logic [3:0] MAX_LVL = 4'(MAX_LEVEL);

  localparam logic [1:0] ACT_FALL  = 2'b00;
  localparam logic [1:0] ACT_LEFT  = 2'b01;
  localparam logic [1:0] ACT_RIGHT = 2'b10;
  localparam logic [1:0] ACT_ROT   = 2'b11;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state, state_next;
  logic          act_req_q, req_next;
  logic [1:0]    act_code_q, code_next;
  logic          pop, consume;

  logic [CW-1:0] grav_cnt;
  logic          grav_pend;
  logic          brk;

  logic [1:0]    fifo_mem [4];
  logic [1:0]    rd_ptr, wr_ptr;
  logic [2:0]    count;

  logic          key_hit, soft_drop, push, drop, tick;
  logic [1:0]    key_act;
  logic [3:0]    lvl_clamp;
  logic [CW-1:0] period_m1;

  assign bus.act_req  = act_req_q;
  assign bus.act_code = act_code_q;
  assign fifo_count   = count;
  assign fsm_state    = state;

  // The byte following a break prefix (F0) is the released key and never decodes.
  always_comb begin
    key_hit   = 1'b0;
    key_act   = ACT_FALL;
    soft_drop = 1'b0;
    if (start_sig && bus.key_valid && !brk) begin
      case (bus.key_code)
        8'h1C: begin key_hit = 1'b1; key_act = ACT_LEFT;  end
        8'h23: begin key_hit = 1'b1; key_act = ACT_RIGHT; end
        8'h1D: begin key_hit = 1'b1; key_act = ACT_ROT;   end
        8'h1B: begin key_hit = 1'b1; key_act = ACT_FALL; soft_drop = 1'b1; end
        default: ;
      endcase
    end
  end

  assign lvl_clamp = (level > MAX_LVL) ? MAX_LVL : level;
  assign period_m1 = CW'(TICK_BASE - int'(lvl_clamp) * TICK_STEP - 1);
  // >= rather than == so a level increase that shortens the period still ticks promptly
  assign tick      = start_sig && (grav_cnt >= period_m1);

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push = key_hit && ((count != 3'd4) || pop);
  assign drop = key_hit && !push;

  always_comb begin
    state_next = state;
    req_next   = act_req_q;
    code_next  = act_code_q;
    pop        = 1'b0;
    consume    = 1'b0;
    case (state)
      IDLE: begin
        if (grav_pend) begin
          consume    = 1'b1;
          req_next   = 1'b1;
          code_next  = ACT_FALL;
          state_next = BUSY;
        end else if (count != 3'd0) begin
          pop        = 1'b1;
          req_next   = 1'b1;
          code_next  = fifo_mem[rd_ptr];
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (bus.act_ack) begin
          req_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!start_sig) begin
      state_next = IDLE;
      req_next   = 1'b0;
      pop        = 1'b0;
      consume    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      act_req_q  <= 1'b0;
      act_code_q <= ACT_FALL;
    end else begin
      state      <= state_next;
      act_req_q  <= req_next;
      act_code_q <= code_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= key_act;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr    <= 2'd0;
      wr_ptr    <= 2'd0;
      count     <= 3'd0;
      overflow  <= 1'b0;
      grav_cnt  <= '0;
      grav_pend <= 1'b0;
      brk       <= 1'b0;
    end else if (!start_sig) begin
      rd_ptr    <= 2'd0;
      wr_ptr    <= 2'd0;
      count     <= 3'd0;
      overflow  <= 1'b0;
      grav_cnt  <= '0;
      grav_pend <= 1'b0;
      brk       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count    <= count + 3'(push) - 3'(pop);
      overflow <= overflow | drop;
      if (bus.key_valid) begin
        if (brk)                        brk <= 1'b0;
        else if (bus.key_code == 8'hF0) brk <= 1'b1;
      end
      if (soft_drop || tick) grav_cnt <= '0;
      else                   grav_cnt <= grav_cnt + CW'(1);
      // A tick arriving while one is still pending is absorbed, not counted.
      grav_pend <= (grav_pend && !consume) || tick;
    end
  end

endmodule
